// File: rtl/hack_pkg.sv
// Shared Hack CPU definitions: word width, reset vector, and the fetch entry
// type (instruction word plus the address it came from).
package hack_pkg;

  localparam int          WORD_W     = 16;
  localparam logic [15:0] RESET_ADDR = 16'h0000;

  typedef struct packed {
    logic [WORD_W-1:0] instr;
    logic [WORD_W-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/inc16.sv
// 16-bit incrementer, combinational, wraps 0xFFFF to 0x0000 with no carry out.
// No state and no backpressure.
module inc16 (
  input  logic [15:0] a_i,
  output logic [15:0] y_o
);

  assign y_o = a_i + 16'd1;

endmodule

// File: rtl/pc_fetch.sv
// Hack fetch stage: PC, ROM read issue, and a 2-deep {instr, pc} buffer to decode.
// Issue-to-valid 2 cycles, redirect-to-valid 3; issue stalls once 2 words are outstanding.
module pc_fetch #(
  parameter int          WIDTH      = 16,
  parameter logic [15:0] RESET_ADDR = hack_pkg::RESET_ADDR
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_addr,
  output logic             rom_en,
  output logic [WIDTH-1:0] rom_addr,
  input  logic [WIDTH-1:0] rom_data,
  output logic [WIDTH-1:0] instr,
  output logic [WIDTH-1:0] instr_pc,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic [WIDTH-1:0] pc
);

  import hack_pkg::*;

  logic [WIDTH-1:0] pc_q, pc_d, pc_inc;
  logic             pend_q, pend_d;
  logic [WIDTH-1:0] pend_pc_q, pend_pc_d;
  logic [1:0]       count_q, count_d, occ, fill;
  fetch_entry_t     ent0_q, ent0_d, ent1_q, ent1_d, new_ent;
  logic             flush, pop, push, issue;

  inc16 u_inc16 (
    .a_i (pc_q),
    .y_o (pc_inc)
  );

  assign flush = clear | load;
  assign pop   = instr_valid & instr_ready;
  assign push  = pend_q & ~flush;
  // Words already buffered plus the one in flight must never exceed the 2 slots.
  assign occ   = count_q + {1'b0, pend_q};
  assign issue = ~flush & ((occ < 2'd2) | pop);

  assign rom_en      = rst_n & issue;
  assign rom_addr    = pc_q;
  assign pc          = pc_q;
  assign instr       = ent0_q.instr;
  assign instr_pc    = ent0_q.pc;
  assign instr_valid = (count_q != 2'd0);
  assign new_ent     = '{instr: rom_data, pc: pend_pc_q};

  always_comb begin
    pc_d      = pc_q;
    pend_d    = issue;
    pend_pc_d = pend_pc_q;
    if (clear) begin
      pc_d = RESET_ADDR;
    end else if (load) begin
      pc_d = load_addr;
    end else if (issue) begin
      pc_d      = pc_inc;
      pend_pc_d = pc_q;
    end
  end

  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    fill   = count_q;
    if (pop) begin
      ent0_d = ent1_q;
      fill   = count_q - 2'd1;
    end
    if (push) begin
      if (fill == 2'd0) ent0_d = new_ent;
      else              ent1_d = new_ent;
      fill = fill + 2'd1;
    end
    count_d = flush ? 2'd0 : fill;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= RESET_ADDR;
      pend_q    <= 1'b0;
      pend_pc_q <= '0;
      count_q   <= 2'd0;
      ent0_q    <= '0;
      ent1_q    <= '0;
    end else begin
      pc_q      <= pc_d;
      pend_q    <= pend_d;
      pend_pc_q <= pend_pc_d;
      count_q   <= count_d;
      ent0_q    <= ent0_d;
      ent1_q    <= ent1_d;
    end
  end

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: streaming, backpressure, redirects, wrap, and mid-run reset.
module tb_pc_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic        load;
  logic [15:0] load_addr;
  logic        rom_en;
  logic [15:0] rom_addr;
  logic [15:0] rom_data = 16'h0000;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] pc;

  int n_cmp = 0;
  int n_err = 0;

  pc_fetch #(.WIDTH(16), .RESET_ADDR(16'h0000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (clear),
    .load        (load),
    .load_addr   (load_addr),
    .rom_en      (rom_en),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .pc          (pc)
  );

  always #5 clk = ~clk;

  // Synchronous ROM: word at address a is a ^ 0xA5A5.
  always @(posedge clk) begin
    if (rom_en) rom_data <= rom_addr ^ 16'hA5A5;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_head(input string tag, input logic [15:0] exp_pc);
    chk({tag, ".valid"}, {31'd0, instr_valid}, 32'd1);
    chk({tag, ".pc"},    {16'd0, instr_pc},    {16'd0, exp_pc});
    chk({tag, ".instr"}, {16'd0, instr},       {16'd0, exp_pc ^ 16'hA5A5});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; clear = 1'b0; load = 1'b0; load_addr = 16'h0000; instr_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst.pc",    {16'd0, pc},          32'h0);
    chk("rst.rom_en",{31'd0, rom_en},      32'h0);
    chk("rst.valid", {31'd0, instr_valid}, 32'h0);
    chk("rst.instr", {16'd0, instr},       32'h0);
    chk("rst.ipc",   {16'd0, instr_pc},    32'h0);

    // Cycle 0 after release issues the reset address.
    rst_n = 1'b1; instr_ready = 1'b1;
    #1;
    chk("c0.rom_en",   {31'd0, rom_en},   32'h1);
    chk("c0.rom_addr", {16'd0, rom_addr}, 32'h0);
    @(negedge clk);
    chk("c1.valid", {31'd0, instr_valid}, 32'h0);
    @(negedge clk);
    for (int p = 0; p < 4; p++) begin
      chk_head("stream", 16'(p));
      @(negedge clk);
    end

    // Backpressure at head pc 4: the pending pc 5 lands, then issue stops.
    chk_head("bp.enter", 16'h0004);
    instr_ready = 1'b0;
    #1;
    chk("bp.rom_en0", {31'd0, rom_en}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk_head("bp.hold", 16'h0004);
      chk("bp.rom_en", {31'd0, rom_en}, 32'h0);
      chk("bp.pc",     {16'd0, pc},     32'h6);
    end
    @(negedge clk);
    chk_head("bp.rel", 16'h0004);
    instr_ready = 1'b1;
    #1;
    chk("bp.rel.rom_en",   {31'd0, rom_en},   32'h1);
    chk("bp.rel.rom_addr", {16'd0, rom_addr}, 32'h6);
    for (int p = 5; p < 8; p++) begin
      @(negedge clk);
      chk_head("bp.cont", 16'(p));
    end

    // Jump with a word buffered and a read in flight.
    load = 1'b1; load_addr = 16'h0100; instr_ready = 1'b0;
    #1;
    chk("ld.rom_en", {31'd0, rom_en}, 32'h0);
    @(negedge clk);
    chk("ld.valid",    {31'd0, instr_valid}, 32'h0);
    chk("ld.rom_addr", {16'd0, rom_addr},    32'h0100);
    load = 1'b0; instr_ready = 1'b1;
    #1;
    chk("ld.issue", {31'd0, rom_en}, 32'h1);
    @(negedge clk);
    chk("ld.stale", {31'd0, instr_valid}, 32'h0);
    @(negedge clk);
    chk_head("ld.first", 16'h0100);
    @(negedge clk);
    chk_head("ld.second", 16'h0101);

    // Clear beats load.
    clear = 1'b1; load = 1'b1; load_addr = 16'h0200;
    #1;
    chk("clr.rom_en", {31'd0, rom_en}, 32'h0);
    @(negedge clk);
    chk("clr.pc",    {16'd0, pc},          32'h0);
    chk("clr.valid", {31'd0, instr_valid}, 32'h0);
    clear = 1'b0; load = 1'b0;
    @(negedge clk);
    chk("clr.valid2", {31'd0, instr_valid}, 32'h0);
    @(negedge clk);
    chk_head("clr.first", 16'h0000);
    @(negedge clk);
    chk_head("clr.second", 16'h0001);

    // Wrap across 0xFFFF.
    load = 1'b1; load_addr = 16'hFFFE;
    @(negedge clk);
    chk("wrap.pc", {16'd0, pc}, 32'hFFFE);
    load = 1'b0;
    @(negedge clk);
    chk("wrap.valid", {31'd0, instr_valid}, 32'h0);
    @(negedge clk);
    chk_head("wrap.0", 16'hFFFE);
    @(negedge clk);
    chk_head("wrap.1", 16'hFFFF);
    @(negedge clk);
    chk_head("wrap.2", 16'h0000);

    // Mid-stream async reset pulse.
    rst_n = 1'b0;
    #1;
    chk("mrst.pc",     {16'd0, pc},          32'h0);
    chk("mrst.rom_en", {31'd0, rom_en},      32'h0);
    chk("mrst.valid",  {31'd0, instr_valid}, 32'h0);
    chk("mrst.instr",  {16'd0, instr},       32'h0);
    chk("mrst.ipc",    {16'd0, instr_pc},    32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mrst.rom_en1",   {31'd0, rom_en},   32'h1);
    chk("mrst.rom_addr1", {16'd0, rom_addr}, 32'h0);
    @(negedge clk);
    chk("mrst.c1.valid", {31'd0, instr_valid}, 32'h0);
    @(negedge clk);
    chk_head("mrst.first", 16'h0000);
    @(negedge clk);
    chk_head("mrst.second", 16'h0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
